game_select_ctrl: RTL and testbench

Top-level game sequencer for the Game & Watch board. Presents a selection menu on the 320x240 monochrome VGA plane, launches one game module at a time by driving its Enable, feeds the shared 16-bit random seed, routes the active game's pixel colour to the display, and returns to the menu when the game raises Quit. Sits between the board key/VGA logic and the per-game modules.

---
 rtl/game_select_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_game_select_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/game_select_ctrl.sv
// game_select_ctrl
//   Top-level game sequencer. Draws the game selection menu on the 320x240
//   monochrome VGA plane, enables one game at a time, feeds all games a
//   shared 16-bit LFSR seed, routes the running game's pixel colour to the
//   display and returns to the menu when that game raises Quit.
//
//   Optional feature: define GSEL_HISCORE_EN to keep a per-game 10-bit high
//   score. Without it HighScore is tied to 0.
//
// Ports
//   Clock, Reset          system clock, synchronous active-high reset
//   Up/Down/Enter/Esc     raw key levels (already synchronised)
//   VGAx, VGAy            current pixel column / row
//   GameCol[i]            pixel colour produced by game i
//   GameQuit[i]           quit request from game i
//   GameScore[10i+9:10i]  score of game i
//   Enable                one-hot enable of the running game
//   Rand                  free-running 16-bit seed
//   VGAcol                displayed pixel colour, 1 = white
//   Sel                   menu cursor / running game index
//   HighScore             best recorded score of game Sel
module game_select_ctrl #(
  parameter int NGAMES      = 4,
  parameter int BLINK_TICKS = 25000000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Up,
  input  logic                   Down,
  input  logic                   Enter,
  input  logic                   Esc,
  input  logic [8:0]             VGAx,
  input  logic [7:0]             VGAy,
  input  logic [NGAMES-1:0]      GameCol,
  input  logic [NGAMES-1:0]      GameQuit,
  input  logic [10*NGAMES-1:0]   GameScore,
  output logic [NGAMES-1:0]      Enable,
  output logic [15:0]            Rand,
  output logic                   VGAcol,
  output logic [1:0]             Sel,
  output logic [9:0]             HighScore
);

  localparam logic [1:0] MENU   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] PLAY   = 2'd2;
  localparam logic [1:0] EXIT   = 2'd3;

  localparam int            BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [1:0]    LAST_SEL   = 2'(NGAMES - 1);

  logic [1:0]    state;
  logic [1:0]    sel;
  logic [2:0]    keys_p0;
  logic [2:0]    press_p1;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic          exit_first;
  logic          game_col;
  logic          game_quit;
  logic [9:0]    game_score;
  logic          exit_ok;
  logic          menu_pix;
  logic          up_press;
  logic          down_press;
  logic          enter_press;

  assign Sel = sel;

  // Key edge detection: previous level, then a registered rising-edge pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      keys_p0  <= '0;
      press_p1 <= '0;
    end else begin
      keys_p0  <= {Enter, Down, Up};
      press_p1 <= {Enter, Down, Up} & ~keys_p0;
    end
  end

  assign up_press    = press_p1[0];
  assign down_press  = press_p1[1];
  assign enter_press = press_p1[2];

  // Signals of the currently selected game
  always_comb begin
    game_col   = 1'b0;
    game_quit  = 1'b0;
    game_score = '0;
    for (int i = 0; i < NGAMES; i++) begin
      if (sel == i[1:0]) begin
        game_col   = GameCol[i];
        game_quit  = GameQuit[i];
        game_score = GameScore[10*i +: 10];
      end
    end
  end

  assign exit_ok = !game_quit && !Enter && !Esc;

  // Sequencer
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= MENU;
      sel        <= 2'd0;
      exit_first <= 1'b0;
    end else begin
      exit_first <= 1'b0;
      case (state)
        MENU: begin
          if (enter_press) begin
            state <= LAUNCH;
          end
          if (up_press && !down_press) begin
            sel <= (sel == 2'd0) ? LAST_SEL : sel - 2'd1;
          end else if (down_press && !up_press) begin
            sel <= (sel == LAST_SEL) ? 2'd0 : sel + 2'd1;
          end
        end
        LAUNCH: state <= PLAY;
        PLAY: begin
          if (game_quit) begin
            state      <= EXIT;
            exit_first <= 1'b1;
          end
        end
        default: begin
          if (exit_ok) begin
            state <= MENU;
          end
        end
      endcase
    end
  end

  always_comb begin
    Enable = '0;
    if (state == PLAY) begin
      for (int i = 0; i < NGAMES; i++) begin
        Enable[i] = (sel == i[1:0]);
      end
    end
  end

  // Seed LFSR: x^16 + x^14 + x^13 + x^11 + 1, maximal length, never zero
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Rand <= 16'hACE1;
    end else begin
      Rand <= {Rand[14:0], Rand[15] ^ Rand[13] ^ Rand[12] ^ Rand[10]};
    end
  end

  // Cursor blink; restarts visible-dark on every return to the menu
  always_ff @(posedge Clock) begin
    if (Reset || (state == EXIT && exit_ok)) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Menu tiles: 56x56 squares at x = 32 + 72i, y = 92, with a 2 px border
  always_comb begin
    int px;
    int py;
    int x0;
    menu_pix = 1'b1;
    px = int'(VGAx);
    py = int'(VGAy);
    for (int i = 0; i < NGAMES; i++) begin
      x0 = 32 + 72 * i;
      if (px >= x0 && px < x0 + 56 && py >= 92 && py < 148) begin
        if (px < x0 + 2 || px >= x0 + 54 || py < 94 || py >= 146) begin
          menu_pix = 1'b0;
        end else begin
          menu_pix = !((sel == i[1:0]) && blink);
        end
      end
    end
  end

  assign VGAcol = (state == PLAY) ? game_col : menu_pix;

`ifdef GSEL_HISCORE_EN
  logic [9:0] score_p1;
  logic [9:0] hiscore [NGAMES];
  logic [9:0] hiscore_sel;

  // Score captured as the game quits
  always_ff @(posedge Clock) begin
    if (state == PLAY && game_quit) begin
      score_p1 <= game_score;
    end
  end

  always_comb begin
    hiscore_sel = '0;
    for (int i = 0; i < NGAMES; i++) begin
      if (sel == i[1:0]) begin
        hiscore_sel = hiscore[i];
      end
    end
  end

  // Update in the first EXIT cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NGAMES; i++) begin
        hiscore[i] <= '0;
      end
    end else if (exit_first && (score_p1 > hiscore_sel)) begin
      for (int i = 0; i < NGAMES; i++) begin
        if (sel == i[1:0]) begin
          hiscore[i] <= score_p1;
        end
      end
    end
  end

  assign HighScore = hiscore_sel;
`else
  logic score_unused;
  assign score_unused = ^{game_score, exit_first};
  assign HighScore    = '0;
`endif

endmodule

// File: tb/tb_game_select_ctrl.sv
module tb_game_select_ctrl;

  logic        Clock;
  logic        Reset;
  logic        Up, Down, Enter, Esc;
  logic [8:0]  VGAx;
  logic [7:0]  VGAy;
  logic [3:0]  GameCol;
  logic [3:0]  GameQuit;
  logic [39:0] GameScore;
  logic [3:0]  Enable;
  logic [15:0] Rand;
  logic        VGAcol;
  logic [1:0]  Sel;
  logic [9:0]  HighScore;

  int total = 0;
  int bad   = 0;

  game_select_ctrl #(.NGAMES(4), .BLINK_TICKS(20)) dut (
    .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .Enter(Enter),
    .Esc(Esc), .VGAx(VGAx), .VGAy(VGAy), .GameCol(GameCol),
    .GameQuit(GameQuit), .GameScore(GameScore), .Enable(Enable),
    .Rand(Rand), .VGAcol(VGAcol), .Sel(Sel), .HighScore(HighScore)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = Up, 1 = Down, 2 = both
  task automatic press(input int kind);
    Up   = (kind == 0 || kind == 2);
    Down = (kind == 1 || kind == 2);
    tick();
    tick();
    Up   = 1'b0;
    Down = 1'b0;
    tick();
  endtask

  function automatic logic [9:0] hs_exp(input logic [9:0] v);
`ifdef GSEL_HISCORE_EN
    return v;
`else
    return 10'd0 & v;
`endif
  endfunction

  // Launch game 2 from the menu, quit with the given score, back to menu
  task automatic play2(input logic [9:0] score, input logic [9:0] hs);
    Enter = 1'b1;
    tick(); tick(); tick();
    chk("play_enable", Enable, 4'b0100);
    Enter = 1'b0;
    tick();
    GameScore = 40'd0;
    GameScore[29:20] = score;
    GameQuit = 4'b0100;
    tick();
    chk("play_quit_enable", Enable, 4'b0000);
    tick();
    chk("play_highscore", HighScore, hs);
    GameQuit = 4'b0000;
    tick();
  endtask

  initial begin
    logic seen_bad;
    Reset = 1'b1; Up = 0; Down = 0; Enter = 0; Esc = 0;
    VGAx = 9'd40; VGAy = 8'd100;
    GameCol = '0; GameQuit = '0; GameScore = '0;
    @(negedge Clock);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_sel", Sel, 2'd0);
    chk("rst_enable", Enable, 4'b0000);
    chk("rst_rand", Rand, 16'hACE1);
    chk("rst_highscore", HighScore, 10'd0);
    #1 chk("rst_pix_40_100", VGAcol, 1'b0);
    VGAx = 9'd0; VGAy = 8'd0;
    #1 chk("rst_pix_0_0", VGAcol, 1'b1);
    VGAx = 9'd32; VGAy = 8'd120;
    #1 chk("border_left_t0", VGAcol, 1'b0);
    VGAx = 9'd88;
    #1 chk("gap_t0_t1", VGAcol, 1'b1);
    VGAx = 9'd130; VGAy = 8'd120;
    #1 chk("t1_interior_unsel", VGAcol, 1'b1);
    VGAx = 9'd130; VGAy = 8'd146;
    #1 chk("t1_border_bottom", VGAcol, 1'b0);

    // Blink: tile 0 interior dark for 20 cycles, then light
    Reset = 1'b0;
    VGAx = 9'd60; VGAy = 8'd120;
    for (int i = 0; i < 19; i++) tick();
    chk("blink_on", VGAcol, 1'b0);
    tick();
    chk("blink_off", VGAcol, 1'b1);
    VGAx = 9'd0; VGAy = 8'd0;

    // Cursor movement
    Down = 1'b1;
    tick();
    chk("down_latency", Sel, 2'd0);
    tick();
    chk("down_1", Sel, 2'd1);
    Down = 1'b0;
    tick();
    press(1); chk("down_2", Sel, 2'd2);
    press(1); chk("down_3", Sel, 2'd3);
    press(1); chk("down_wrap", Sel, 2'd0);
    press(0); chk("up_wrap", Sel, 2'd3);
    press(2); chk("up_down_same", Sel, 2'd3);
    press(0); chk("up_to_2", Sel, 2'd2);
    Esc = 1'b1; tick(); Esc = 1'b0; tick();
    chk("esc_menu", Sel, 2'd2);

    // Launch game 2
    Enter = 1'b1;
    tick(); tick();
    chk("launch_enable_off", Enable, 4'b0000);
    tick();
    chk("play_enable_3cyc", Enable, 4'b0100);
    Enter = 1'b0;
    GameCol = 4'b0100;
    #1 chk("play_col_hi", VGAcol, 1'b1);
    GameCol = 4'b1011;
    #1 chk("play_col_lo", VGAcol, 1'b0);
    GameQuit = 4'b0010;
    tick();
    GameQuit = 4'b0000;
    tick();
    chk("other_quit_ignored", Enable, 4'b0100);
    press(1);
    chk("down_in_play_sel", Sel, 2'd2);
    chk("down_in_play_en", Enable, 4'b0100);

    // Quit with score 37
    GameCol = 4'b0000;
    GameScore = 40'd0;
    GameScore[29:20] = 10'd37;
    GameQuit = 4'b0100;
    tick();
    chk("quit_enable_off", Enable, 4'b0000);
    #1 chk("exit_menu_pixel", VGAcol, 1'b1);
    tick();
    chk("hs_37", HighScore, hs_exp(10'd37));
    press(1);
    chk("exit_holds_sel", Sel, 2'd2);
    chk("exit_holds_enable", Enable, 4'b0000);
    GameQuit = 4'b0000;
    tick();
    VGAx = 9'd196; VGAy = 8'd120;
    #1 chk("menu_blink_restart", VGAcol, 1'b0);
    VGAx = 9'd0; VGAy = 8'd0;
    press(1); chk("menu_again_down", Sel, 2'd3);
    chk("hs_game3", HighScore, 10'd0);
    press(0); chk("menu_again_up", Sel, 2'd2);
    chk("hs_back_2", HighScore, hs_exp(10'd37));

    play2(10'd12, hs_exp(10'd37));
    play2(10'd40, hs_exp(10'd40));
    chk("hs_after_40", HighScore, hs_exp(10'd40));

    // Reset in the middle of a game
    Enter = 1'b1;
    tick(); tick(); tick();
    Enter = 1'b0;
    chk("replay_enable", Enable, 4'b0100);
    Reset = 1'b1;
    tick();
    chk("rst_mid_enable", Enable, 4'b0000);
    chk("rst_mid_sel", Sel, 2'd0);
    chk("rst_mid_rand", Rand, 16'hACE1);
    Reset = 1'b0;
    press(1); press(1);
    chk("rst_mid_sel2", Sel, 2'd2);
    chk("rst_mid_hs_cleared", HighScore, 10'd0);

    // LFSR period
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    seen_bad = 1'b0;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (k < 65535 && (Rand == 16'h0000 || Rand == 16'hACE1)) seen_bad = 1'b1;
    end
    chk("rand_no_zero_or_early_repeat", seen_bad, 1'b0);
    chk("rand_period", Rand, 16'hACE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
